v810_prefetch: RTL and testbench
================================

# v810_prefetch

Instruction prefetch queue for the V810 core. It sits directly upstream of `v810_exec`'s decode, between the instruction memory port and the execution stage. It streams sequential 16-bit halfwords from a synchronous memory with one-cycle read latency into a small circular queue. It exposes the oldest two halfwords, so decode can consume 16- or 32-bit instructions. Branch redirects flush the queue and discard any fetch still in flight.

## Interface
- `DEPTH`, 4: queue capacity in halfwords; power of 2, at least 2.
- `RESET_PC`, 32'hFFFF_FFF0: fetch address after reset; bit 0 must be 0.

Ports:
- `CLK` in 1: single clock.
- `RESn` in 1: reset, asynchronous, active-low.
- `CE` in 1: clock enable; all state holds when 0.
- `IA` out 32: fetch address, driven from the fetch-PC register `FPC`.
- `IA_VALID` out 1: fetch issued this cycle (combinational).
- `ID` in 16: memory read data, valid the cycle after the issue.
- `JMP` in 1: redirect request.
- `JMP_PC` in 32: redirect target; bit 0 is ignored and forced to 0.
- `POP` in 2: consume from head; 00 none, 01 one halfword, 10 or 11 two halfwords.
- `Q_CNT` out $clog2(DEPTH+1): halfwords available.
- `Q_HW0` out 16: head halfword; 0 when `Q_CNT`=0.
- `Q_HW1` out 16: second halfword; 0 when `Q_CNT`<2.
- `Q_PC` out 32: address of `Q_HW0`.

## Operation
- State:
  - `FPC`: fetch PC, 32 bits.
  - `INFL`: one-fetch-in-flight flag.
  - Circular buffer with head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`.
  - `Q_PC`.
- Reset (async, `RESn`=0):
  - `FPC`=`IA`=`RESET_PC`; `Q_PC`=`RESET_PC`.
  - `count`=0, `INFL`=0, pointers=0.
  - `Q_CNT`=0, `Q_HW0`=`Q_HW1`=0.
  - `IA_VALID` evaluates to 1 once `RESn` is high.
- Issue: `IA_VALID` = `RESn` & !`JMP` & (`count` + `INFL` < DEPTH). The issue check ignores a same-cycle POP (conservative credit).
- On a CE edge with `IA_VALID`: `FPC` += 2, wrapping mod 2^32; `INFL` <= 1. Otherwise `INFL` <= 0.
- Return: on a CE edge with `INFL`=1 and `JMP`=0, `ID` is written at the tail and the tail advances.
- Pop:
  - npop = 0, 1 or 2 from `POP`.
  - If npop > `count`, the whole pop is ignored (no partial pop).
  - Otherwise the head advances by npop and `Q_PC` += 2*npop.
- Occupancy: `count` <= `count` + wr − npop. A write and a pop in the same cycle are legal in any combination, including a full queue with pop + write.
- No bypass: a halfword written at an edge becomes visible in `Q_HW0`/`Q_HW1` only after that edge.
- Redirect: on a CE edge with `JMP`=1, JMP has priority over POP and return.
  - `count`=0 and head=tail.
  - In-flight data is dropped and `INFL`=0.
  - `FPC`=`Q_PC`={`JMP_PC`[31:1],0}.
- CE=0 suppresses every update. `IA` and `IA_VALID` keep their combinational values, and the memory must not be clocked with CE low.
- Reset mid-operation: immediate return to the reset state; in-flight data is lost.

## Timing
- Memory contract: `IA` is sampled by memory at the end of cycle k; `ID` is valid throughout k+1 and captured at the end of k+1.
- Reset release, first CE cycle c0: `IA`=`RESET_PC`, `IA_VALID`=1.
  - End of c1: first halfword written.
  - c2: `Q_CNT`=1, `Q_HW0`=mem[`RESET_PC`].
- Redirect asserted in cycle t:
  - t+1: `IA`=target, `IA_VALID`=1.
  - t+3: `Q_CNT`≥1, `Q_PC`=target.
- Steady state sustains 1 halfword/cycle with no consumer stall.
- With no pops, `Q_CNT` saturates at DEPTH and `IA_VALID` stays 0.
- `Q_HW0`, `Q_HW1`, `Q_CNT` and `Q_PC` are registered or direct mux outputs of registered state; none depend combinationally on `POP`.

## Test plan
- Reset fetch:
  - Stimulus: `RESn` low→high, mem[i]=i, `RESET_PC`=0.
  - Required: `IA` sequence 0,2,4,6; `Q_CNT` reaches 4; `Q_HW0`=0, `Q_HW1`=1; `IA_VALID`=0 while full.
- Pop mix:
  - Stimulus: full queue, POP=10, then 01 on consecutive cycles.
  - Required: `Q_PC` 0→4→6; `Q_HW0` 0→2→3; refill resumes so `Q_CNT` returns to 4.
- Redirect with fetch in flight:
  - Stimulus: `JMP`=1, `JMP_PC`=0x101 in the cycle after an issue.
  - Required: stale `ID` is not queued; next `IA`=0x100; `Q_PC`=0x100; first `Q_HW0`=mem[0x100].
- Illegal pop:
  - Stimulus: `Q_CNT`=1, POP=10.
  - Required: no change to `Q_CNT`/`Q_PC`; an incoming write still makes `Q_CNT`=2.
- CE hold:
  - Stimulus: CE=0 for 5 cycles mid-stream with POP and JMP toggling.
  - Required: all outputs and `FPC` frozen; resumes identically to an uninterrupted run.
- Async reset mid-stream:
  - Stimulus: `RESn` pulse between clock edges while queue is partially full.
  - Required: `Q_CNT`=0, `IA`=`RESET_PC` immediately; no stale `ID` enters the queue after release.

Source files
------------

// File: rtl/v810_prefetch.sv
// V810 instruction prefetch queue: streams sequential halfwords from a one-cycle-latency
// memory into a circular buffer and presents the oldest two halfwords to decode.
module v810_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0
) (
  input  logic                       CLK,
  input  logic                       RESn,
  input  logic                       CE,
  output logic [31:0]                IA,
  output logic                       IA_VALID,
  input  logic [15:0]                ID,
  input  logic                       JMP,
  input  logic [31:0]                JMP_PC,
  input  logic [1:0]                 POP,
  output logic [$clog2(DEPTH+1)-1:0] Q_CNT,
  output logic [15:0]                Q_HW0,
  output logic [15:0]                Q_HW1,
  output logic [31:0]                Q_PC
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   qpc_q, qpc_d;
  logic          infl_q, infl_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   fifo_q [DEPTH];

  logic [1:0]    npop;
  logic [1:0]    npop_eff;
  logic          pop_ok;
  logic          issue;
  logic          wr;
  logic [31:0]   occ;
  logic [31:0]   jmp_target;
  logic [PW-1:0] head_nx;
  logic          unused_jmp_lsb;

  assign unused_jmp_lsb = JMP_PC[0];
  assign jmp_target     = {JMP_PC[31:1], 1'b0};

  always_comb begin
    unique case (POP)
      2'b00:   npop = 2'd0;
      2'b01:   npop = 2'd1;
      default: npop = 2'd2;
    endcase
  end

  // A pop that asks for more than is queued is dropped whole, never partially applied.
  assign pop_ok   = (CW'(npop) <= cnt_q);
  assign npop_eff = pop_ok ? npop : 2'd0;

  // Credit counts the fetch in flight and ignores a same-cycle pop.
  assign occ   = 32'(cnt_q) + 32'(infl_q);
  assign issue = RESn & ~JMP & (occ < DEPTH);
  assign wr    = infl_q & ~JMP;

  always_comb begin
    fpc_d  = fpc_q;
    qpc_d  = qpc_q;
    infl_d = infl_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (JMP) begin
      fpc_d  = jmp_target;
      qpc_d  = jmp_target;
      infl_d = 1'b0;
      head_d = tail_q;
      cnt_d  = '0;
    end else begin
      infl_d = issue;
      if (issue) begin
        fpc_d = fpc_q + 32'd2;
      end
      if (wr) begin
        tail_d = tail_q + PW'(1);
      end
      head_d = head_q + PW'(npop_eff);
      qpc_d  = qpc_q + {29'd0, npop_eff, 1'b0};
      cnt_d  = cnt_q + CW'(wr) - CW'(npop_eff);
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      fpc_q  <= RESET_PC;
      qpc_q  <= RESET_PC;
      infl_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (CE) begin
      fpc_q  <= fpc_d;
      qpc_q  <= qpc_d;
      infl_q <= infl_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: reads are masked by the occupancy count.
  always_ff @(posedge CLK) begin
    if (CE && wr) begin
      fifo_q[tail_q] <= ID;
    end
  end

  assign head_nx  = head_q + PW'(1);
  assign IA       = fpc_q;
  assign IA_VALID = issue;
  assign Q_CNT    = cnt_q;
  assign Q_PC     = qpc_q;
  assign Q_HW0    = (cnt_q != '0) ? fifo_q[head_q] : 16'd0;
  assign Q_HW1    = (cnt_q >= CW'(2)) ? fifo_q[head_nx] : 16'd0;

endmodule

// File: tb/tb_v810_prefetch.sv
// Bench for v810_prefetch: fixed vector table, directed corner sequences and a random run,
// all checked against a queue-based reference model.
module tb_v810_prefetch;
  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b0;
  logic [31:0] IA;
  logic        IA_VALID;
  logic [15:0] ID = '0;
  logic        JMP = 1'b0;
  logic [31:0] JMP_PC = '0;
  logic [1:0]  POP = '0;
  logic [2:0]  Q_CNT;
  logic [15:0] Q_HW0;
  logic [15:0] Q_HW1;
  logic [31:0] Q_PC;

  v810_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .IA(IA), .IA_VALID(IA_VALID), .ID(ID),
    .JMP(JMP), .JMP_PC(JMP_PC), .POP(POP), .Q_CNT(Q_CNT), .Q_HW0(Q_HW0),
    .Q_HW1(Q_HW1), .Q_PC(Q_PC)
  );

  always #5 CLK = ~CLK;

  // Memory image: halfword at byte address a holds a/2 (low 16 bits).
  function automatic logic [15:0] mem_at(input logic [31:0] a);
    return a[16:1];
  endfunction

  always @(posedge CLK) if (RESn && CE && IA_VALID) ID <= mem_at(IA);

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: fetch PC, optional in-flight address, queue of halfwords.
  logic [31:0] m_fpc, m_qpc, m_infl_addr;
  bit          m_infl;
  logic [15:0] m_q[$];

  task automatic model_reset();
    m_fpc = 32'h0; m_qpc = 32'h0; m_infl = 0; m_infl_addr = '0;
    m_q.delete();
  endtask

  function automatic bit model_iav();
    return RESn && !JMP && (m_q.size() + int'(m_infl) < DEPTH);
  endfunction

  task automatic model_check();
    check("IA", IA, m_fpc);
    check("IA_VALID", 32'(IA_VALID), 32'(model_iav()));
    check("Q_CNT", 32'(Q_CNT), 32'(m_q.size()));
    check("Q_HW0", 32'(Q_HW0), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check("Q_HW1", 32'(Q_HW1), (m_q.size() > 1) ? 32'(m_q[1]) : 32'd0);
    check("Q_PC", Q_PC, m_qpc);
  endtask

  task automatic model_update();
    int n, oldsz;
    bit iav;
    if (!CE) return;
    if (JMP) begin
      m_q.delete();
      m_infl = 0;
      m_fpc = {JMP_PC[31:1], 1'b0};
      m_qpc = m_fpc;
      return;
    end
    iav = model_iav();
    n = (POP == 2'd0) ? 0 : (POP == 2'd1) ? 1 : 2;
    oldsz = m_q.size();
    if (m_infl) m_q.push_back(mem_at(m_infl_addr));
    if (n <= oldsz) begin
      repeat (n) void'(m_q.pop_front());
      m_qpc = m_qpc + 32'(2 * n);
    end
    if (iav) begin
      m_infl_addr = m_fpc;
      m_fpc = m_fpc + 32'd2;
      m_infl = 1;
    end else begin
      m_infl = 0;
    end
  endtask

  task automatic drive(input bit ce, input bit jmp, input logic [31:0] jpc,
                       input logic [1:0] pop);
    CE = ce; JMP = jmp; JMP_PC = jpc; POP = pop;
    @(negedge CLK);
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input bit ce, input bit jmp, input logic [31:0] jpc,
                      input logic [1:0] pop);
    drive(ce, jmp, jpc, pop);
    advance();
  endtask

  typedef struct {
    logic [1:0]  pop;
    int          cnt;
    logic [15:0] hw0;
    logic [15:0] hw1;
    logic [31:0] pc;
    logic [31:0] ia;
    bit          iav;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // Reset fill then pop mix: cycles c0..c11 after reset release.
    tbl[0]  = '{2'd0, 0, 16'd0, 16'd0, 32'd0, 32'd0,  1'b1};
    tbl[1]  = '{2'd0, 0, 16'd0, 16'd0, 32'd0, 32'd2,  1'b1};
    tbl[2]  = '{2'd0, 1, 16'd0, 16'd0, 32'd0, 32'd4,  1'b1};
    tbl[3]  = '{2'd0, 2, 16'd0, 16'd1, 32'd0, 32'd6,  1'b1};
    tbl[4]  = '{2'd0, 3, 16'd0, 16'd1, 32'd0, 32'd8,  1'b0};
    tbl[5]  = '{2'd0, 4, 16'd0, 16'd1, 32'd0, 32'd8,  1'b0};
    tbl[6]  = '{2'd2, 4, 16'd0, 16'd1, 32'd0, 32'd8,  1'b0};
    tbl[7]  = '{2'd1, 2, 16'd2, 16'd3, 32'd4, 32'd8,  1'b1};
    tbl[8]  = '{2'd0, 1, 16'd3, 16'd0, 32'd6, 32'd10, 1'b1};
    tbl[9]  = '{2'd0, 2, 16'd3, 16'd4, 32'd6, 32'd12, 1'b1};
    tbl[10] = '{2'd0, 3, 16'd3, 16'd4, 32'd6, 32'd14, 1'b0};
    tbl[11] = '{2'd0, 4, 16'd3, 16'd4, 32'd6, 32'd14, 1'b0};

    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_IA", IA, 32'h0);
    check("rst_IA_VALID", 32'(IA_VALID), 32'd0);
    check("rst_Q_CNT", 32'(Q_CNT), 32'd0);
    check("rst_Q_HW0", 32'(Q_HW0), 32'd0);
    check("rst_Q_PC", Q_PC, 32'h0);
    RESn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 32'h0, tbl[i].pop);
      check($sformatf("tbl%0d_cnt", i), 32'(Q_CNT), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_hw0", i), 32'(Q_HW0), 32'(tbl[i].hw0));
      check($sformatf("tbl%0d_hw1", i), 32'(Q_HW1), 32'(tbl[i].hw1));
      check($sformatf("tbl%0d_pc", i), Q_PC, tbl[i].pc);
      check($sformatf("tbl%0d_ia", i), IA, tbl[i].ia);
      check($sformatf("tbl%0d_iav", i), 32'(IA_VALID), 32'(tbl[i].iav));
      advance();
    end

    // Redirect one cycle after an issue; the stale fetch (addr 14) must be dropped.
    step(1'b1, 1'b0, 32'h0, 2'd1);
    step(1'b1, 1'b0, 32'h0, 2'd0);
    step(1'b1, 1'b1, 32'h101, 2'd0);
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    check("jmp_IA", IA, 32'h100);
    check("jmp_IA_VALID", 32'(IA_VALID), 32'd1);
    check("jmp_Q_PC", Q_PC, 32'h100);
    check("jmp_Q_CNT", 32'(Q_CNT), 32'd0);
    advance();
    step(1'b1, 1'b0, 32'h0, 2'd0);
    // t+3 with one entry: a two-halfword pop is illegal, the incoming write still lands.
    drive(1'b1, 1'b0, 32'h0, 2'd2);
    check("jmp3_Q_CNT", 32'(Q_CNT), 32'd1);
    check("jmp3_Q_HW0", 32'(Q_HW0), 32'h80);
    advance();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    check("ipop_Q_CNT", 32'(Q_CNT), 32'd2);
    check("ipop_Q_PC", Q_PC, 32'h100);
    check("ipop_Q_HW1", 32'(Q_HW1), 32'h81);
    advance();

    // Clock-enable hold with POP and JMP toggling.
    step(1'b1, 1'b0, 32'h0, 2'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2), 32'h200, 2'(i % 3 + 1));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 2'(i % 2));

    // Async reset pulse between edges while partially full with a fetch in flight.
    step(1'b1, 1'b0, 32'h0, 2'd1);
    CE = 1'b1; JMP = 1'b0; POP = 2'd0;
    #1 RESn = 1'b0;
    #1;
    check("arst_Q_CNT", 32'(Q_CNT), 32'd0);
    check("arst_IA", IA, 32'h0);
    check("arst_Q_HW0", 32'(Q_HW0), 32'd0);
    check("arst_Q_PC", Q_PC, 32'h0);
    #1 RESn = 1'b1;
    model_reset();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    check("arst_c0_cnt", 32'(Q_CNT), 32'd0);
    advance();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    check("arst_c1_cnt", 32'(Q_CNT), 32'd0);
    advance();
    drive(1'b1, 1'b0, 32'h0, 2'd0);
    check("arst_c2_cnt", 32'(Q_CNT), 32'd1);
    check("arst_c2_hw0", 32'(Q_HW0), 32'd0);
    advance();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), $urandom,
           2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
